// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, instruction fields, flag indices and FSM states shared by the ALU issue controller.
package alu_pkg;
    localparam logic [5:0] OP_ADD = 6'b010000;
    localparam logic [5:0] OP_OR  = 6'b010001;
    localparam logic [5:0] OP_NOR = 6'b010010;
    localparam logic [5:0] OP_XOR = 6'b010011;
    localparam logic [5:0] OP_RLS = 6'b001100;
    localparam logic [5:0] OP_LLS = 6'b001101;
    localparam int INSTR_OP_LSB = 26;
    localparam int INSTR_RD_LSB = 22;
    localparam int INSTR_RA_LSB = 18;
    localparam int INSTR_RB_LSB = 14;
    localparam int FLG_OVER  = 3;
    localparam int FLG_CARRY = 2;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_NEG   = 0;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    // AND shares ADD's code at the ALU, so it is deliberately absent here
    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_ADD, OP_OR, OP_NOR, OP_XOR, OP_RLS, OP_LLS};
    endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction handshake, host preload, debug read and ALU operand/result bus.
interface alu_issue_ctrl_if #(parameter int DW = 32);
    logic          InstrValid;
    logic          InstrReady;
    logic [31:0]   Instr;
    logic          HostWrEn;
    logic [3:0]    HostWrAddr;
    logic [DW-1:0] HostWrData;
    logic [3:0]    DbgAddr;
    logic [DW-1:0] DbgData;
    logic [DW-1:0] AluA;
    logic [DW-1:0] AluB;
    logic [5:0]    AluOp;
    logic [DW-1:0] AluResult;
    logic [3:0]    AluStatus;
    logic [3:0]    Flags;
    logic          Done;
    logic          Error;
    modport master (
        output InstrValid, Instr, HostWrEn, HostWrAddr, HostWrData, DbgAddr, AluResult, AluStatus,
        input  InstrReady, DbgData, AluA, AluB, AluOp, Flags, Done, Error
    );
    modport slave (
        input  InstrValid, Instr, HostWrEn, HostWrAddr, HostWrData, DbgAddr, AluResult, AluStatus,
        output InstrReady, DbgData, AluA, AluB, AluOp, Flags, Done, Error
    );
endinterface

// File: rtl/issue_regfile.sv
// issue_regfile: 16x32 register file with two operand read ports, a debug read port and one write port.
module issue_regfile #(
    parameter int NREGS = 16,
    parameter int DW = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] ra_i,
    input  logic [AW-1:0] rb_i,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [DW-1:0] rd_a_o,
    output logic [DW-1:0] rd_b_o,
    output logic [DW-1:0] dbg_data_o
);
    logic [DW-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) regs_q <= '{default: '0};
        else if (we_i) regs_q[waddr_i] <= wdata_i;
    end

    assign rd_a_o = regs_q[ra_i];
    assign rd_b_o = regs_q[rb_i];
    assign dbg_data_o = regs_q[dbg_addr_i];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues register-file operands to a registered ALU and writes its result back,
// updating flags on ADD and pulsing Done per instruction.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW = 32
) (
    input logic Clock,
    input logic Reset,
    alu_issue_ctrl_if.slave bus
);
    state_t state_q, state_d;
    logic [5:0] op_q;
    logic [3:0] rd_q;
    logic [DW-1:0] alu_a_q, alu_b_q;
    logic [5:0] alu_op_q;
    logic [3:0] flags_q;
    logic done_q, error_q;
    logic [5:0] instr_op;
    logic [3:0] instr_rd, instr_ra, instr_rb;
    logic accept, legal, host_we, wb_we;
    logic [DW-1:0] rf_a, rf_b;

    assign instr_op = bus.Instr[INSTR_OP_LSB +: 6];
    assign instr_rd = bus.Instr[INSTR_RD_LSB +: 4];
    assign instr_ra = bus.Instr[INSTR_RA_LSB +: 4];
    assign instr_rb = bus.Instr[INSTR_RB_LSB +: 4];
    assign accept = (state_q == S_IDLE) && bus.InstrValid;
    assign legal = op_legal(instr_op);
    assign host_we = (state_q == S_IDLE) && bus.HostWrEn;
    assign wb_we = (state_q == S_WAIT);

    issue_regfile #(.NREGS(NREGS), .DW(DW)) u_rf (
        .clk       (Clock),
        .rst       (Reset),
        .we_i      (host_we || wb_we),
        .waddr_i   (wb_we ? rd_q : bus.HostWrAddr),
        .wdata_i   (wb_we ? bus.AluResult : bus.HostWrData),
        .ra_i      (instr_ra),
        .rb_i      (instr_rb),
        .dbg_addr_i(bus.DbgAddr),
        .rd_a_o    (rf_a),
        .rd_b_o    (rf_b),
        .dbg_data_o(bus.DbgData)
    );

    always_comb begin
        state_d = state_q;
        state_d = (state_q == S_IDLE)  ? (accept ? (legal ? S_ISSUE : S_DONE) : S_IDLE) :
                  (state_q == S_ISSUE) ? S_WAIT :
                  (state_q == S_WAIT)  ? S_DONE : S_IDLE;
    end

    // operands are captured at accept, so a same-edge preload must be forwarded
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q <= '0;
            rd_q <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            alu_op_q <= '0;
            flags_q <= '0;
            done_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q <= (state_d == S_DONE);
            error_q <= (state_q == S_IDLE) && (state_d == S_DONE);
            alu_op_q <= (state_d == S_ISSUE) ? instr_op : 6'b000000;
            if (accept && legal) begin
                op_q <= instr_op;
                rd_q <= instr_rd;
                alu_a_q <= (host_we && bus.HostWrAddr == instr_ra) ? bus.HostWrData : rf_a;
                alu_b_q <= (host_we && bus.HostWrAddr == instr_rb) ? bus.HostWrData : rf_b;
            end
            if (wb_we && op_q == OP_ADD) begin
                flags_q[FLG_OVER] <= bus.AluStatus[FLG_OVER];
                flags_q[FLG_CARRY] <= bus.AluStatus[FLG_CARRY];
                flags_q[FLG_ZERO] <= (bus.AluResult == '0);
                flags_q[FLG_NEG] <= bus.AluStatus[FLG_NEG];
            end
        end
    end

    assign bus.InstrReady = (state_q == S_IDLE);
    assign bus.AluA = alu_a_q;
    assign bus.AluB = alu_b_q;
    assign bus.AluOp = alu_op_q;
    assign bus.Flags = flags_q;
    assign bus.Done = done_q;
    assign bus.Error = error_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random instructions against an instruction-level register/flag model.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] m_rf [16];
    logic [3:0] m_flags;
    logic [5:0] legal_ops [6];

    alu_issue_ctrl_if #(.DW(32)) bus ();

    alu_issue_ctrl #(.NREGS(16), .DW(32)) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            6'b010000: return a + b;
            6'b010001: return a | b;
            6'b010010: return ~(a | b);
            6'b010011: return a ^ b;
            6'b001100: return a >> b[4:0];
            6'b001101: return a << b[4:0];
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] add_flags(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {(a[31] == b[31]) && (s[31] != a[31]), s[32], s[31:0] == 32'h0, s[31]};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b010000, 6'b010001, 6'b010010, 6'b010011, 6'b001100, 6'b001101};
    endfunction

    // stand-in registered ALU; its zero status bit is noise, the controller must derive Zero itself
    always @(posedge clk) begin
        if (bus.AluOp != 6'b000000) begin
            bus.AluResult <= alu_fn(bus.AluOp, bus.AluA, bus.AluB);
            bus.AluStatus <= {add_flags(bus.AluA, bus.AluB)[3:2], 1'($urandom), add_flags(bus.AluA, bus.AluB)[0]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dbg(input logic [3:0] a, output logic [31:0] d);
        bus.DbgAddr = a;
        #1 d = bus.DbgData;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            dbg(4'(i), d);
            check(tag, d, m_rf[i]);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.HostWrEn = 1'b1;
        bus.HostWrAddr = a;
        bus.HostWrData = d;
        m_rf[a] = d;
        @(negedge clk);
        bus.HostWrEn = 1'b0;
    endtask

    // mode 0: no host write, 1: host write on the accept edge, 2: host write during ISSUE (ignored)
    task automatic run(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb,
                       input int mode, input logic [3:0] pa, input logic [31:0] pd);
        logic [31:0] a, b, d;
        @(negedge clk);
        check("ready_idle", 32'(bus.InstrReady), 32'd1);
        bus.Instr = {op, rd, ra, rb, 14'($urandom)};
        bus.InstrValid = 1'b1;
        if (mode == 1) begin
            bus.HostWrEn = 1'b1;
            bus.HostWrAddr = pa;
            bus.HostWrData = pd;
            m_rf[pa] = pd;
        end
        @(negedge clk);
        bus.InstrValid = 1'b0;
        bus.HostWrEn = 1'b0;
        if (is_legal(op)) begin
            a = m_rf[ra];
            b = m_rf[rb];
            check("issue_op", 32'(bus.AluOp), 32'(op));
            check("issue_a", bus.AluA, a);
            check("issue_b", bus.AluB, b);
            check("issue_done", 32'(bus.Done), 32'd0);
            check("issue_ready", 32'(bus.InstrReady), 32'd0);
            if (mode == 2) begin
                bus.HostWrEn = 1'b1;
                bus.HostWrAddr = pa;
                bus.HostWrData = pd;
            end
            @(negedge clk);
            bus.HostWrEn = 1'b0;
            check("wait_op", 32'(bus.AluOp), 32'd0);
            check("wait_done", 32'(bus.Done), 32'd0);
            @(negedge clk);
            m_rf[rd] = alu_fn(op, a, b);
            if (op == 6'b010000) m_flags = add_flags(a, b);
            check("done", 32'(bus.Done), 32'd1);
            check("done_err", 32'(bus.Error), 32'd0);
            check("done_op", 32'(bus.AluOp), 32'd0);
        end else begin
            check("ill_op", 32'(bus.AluOp), 32'd0);
            check("ill_done", 32'(bus.Done), 32'd1);
            check("ill_err", 32'(bus.Error), 32'd1);
        end
        @(negedge clk);
        check("done_pulse", 32'(bus.Done), 32'd0);
        check("back_idle", 32'(bus.InstrReady), 32'd1);
        check("flags", 32'(bus.Flags), 32'(m_flags));
        dbg(rd, d);
        check("rd_val", d, m_rf[rd]);
        if (mode == 2) begin
            dbg(pa, d);
            check("issue_wr_ignored", d, m_rf[pa]);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [5:0] op;
        legal_ops = '{6'b010000, 6'b010001, 6'b010010, 6'b010011, 6'b001100, 6'b001101};
        for (int i = 0; i < 16; i++) m_rf[i] = 32'h0;
        m_flags = 4'h0;
        bus.InstrValid = 1'b0;
        bus.Instr = 32'h0;
        bus.HostWrEn = 1'b0;
        bus.HostWrAddr = 4'h0;
        bus.HostWrData = 32'h0;
        bus.DbgAddr = 4'h0;
        bus.AluResult = 32'h0;
        bus.AluStatus = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_err", 32'(bus.Error), 32'd0);
        check("rst_flags", 32'(bus.Flags), 32'd0);
        check("rst_op", 32'(bus.AluOp), 32'd0);
        check("rst_a", bus.AluA, 32'd0);
        check("rst_b", bus.AluB, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.InstrReady), 32'd1);
        check_all("rst_regs");

        preload(4'd1, 32'd5);
        preload(4'd2, 32'd3);
        run(6'b010000, 4'd3, 4'd1, 4'd2, 0, 4'd0, 32'h0);
        dbg(4'd3, d);
        check("add_r3", d, 32'd8);
        check("add_flags", 32'(bus.Flags), 32'h0);

        preload(4'd1, 32'h7FFF_FFFF);
        run(6'b010000, 4'd4, 4'd1, 4'd2, 1, 4'd2, 32'd1);
        dbg(4'd4, d);
        check("ovf_r4", d, 32'h8000_0000);
        check("ovf_flags", 32'(bus.Flags), 32'b1001);

        preload(4'd1, 32'hFFFF_FFFF);
        run(6'b010000, 4'd5, 4'd1, 4'd2, 0, 4'd0, 32'h0);
        dbg(4'd5, d);
        check("carry_r5", d, 32'h0);
        check("carry_flags", 32'(bus.Flags), 32'b0110);

        preload(4'd1, 32'hF0F0_F0F0);
        preload(4'd2, 32'hFF00_FF00);
        run(6'b010011, 4'd6, 4'd1, 4'd2, 2, 4'd9, 32'hDEAD_BEEF);
        dbg(4'd6, d);
        check("xor_r6", d, 32'h0FF0_0FF0);
        check("xor_flags", 32'(bus.Flags), 32'b0110);

        run(6'b111111, 4'd8, 4'd1, 4'd2, 0, 4'd0, 32'h0);
        check_all("ill_regs");

        @(negedge clk);
        bus.Instr = {6'b010000, 4'd7, 4'd1, 4'd2, 14'h0};
        bus.InstrValid = 1'b1;
        @(negedge clk);
        bus.InstrValid = 1'b0;
        check("rstmid_issue", 32'(bus.AluOp), 32'(6'b010000));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = 32'h0;
        m_flags = 4'h0;
        check("rstmid_done", 32'(bus.Done), 32'd0);
        check("rstmid_ready", 32'(bus.InstrReady), 32'd1);
        check("rstmid_flags", 32'(bus.Flags), 32'd0);
        @(negedge clk);
        check("rstmid_nodone", 32'(bus.Done), 32'd0);
        dbg(4'd7, d);
        check("rstmid_r7", d, 32'h0);
        check_all("rstmid_regs");

        for (int i = 0; i < 16; i++) preload(4'(i), $urandom);
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 7) < 6) ? legal_ops[$urandom_range(0, 5)] : 6'($urandom);
            run(op, 4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 4'($urandom), $urandom);
        end
        check_all("final_regs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operand/opcode interface.
- Accepts 32-bit instruction words over a valid/ready handshake and reads operands from a local register file.
- Drives the registered ALU's DataA/DataB/OPCode inputs, then captures ResultC and Status one clock later.
- Writes the result back to the register file, updates the architectural flags, and signals completion.

Parameters:
- NREGS, 16, register file depth; must be 16 for the 4-bit register fields.
- DW, 32, datapath width; matches ALU operands.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- InstrValid  in  1  instruction word present.
- InstrReady  out  1  high only in IDLE.
- Instr  in  32  fields: [31:26] op, [25:22] rd, [21:18] ra, [17:14] rb, [13:0] ignored.
- HostWrEn  in  1  register preload strobe.
- HostWrAddr  in  4  preload address.
- HostWrData  in  32  preload data.
- DbgAddr  in  4  debug read address.
- DbgData  out  32  combinational read of regfile[DbgAddr].
- AluA  out  32  to ALU DataA.
- AluB  out  32  to ALU DataB.
- AluOp  out  6  to ALU OPCode.
- AluResult  in  32  from ALU ResultC.
- AluStatus  in  4  from ALU Status.
- Flags  out  4  {Over, Carry, Zero, Neg}.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  valid with Done; illegal opcode.

Behaviour:
- Reset: state=IDLE, all 16 registers=0, Flags=0, Done=0, Error=0, AluA=0, AluB=0, AluOp=6'b000000. Reset mid-operation abandons the instruction with no writeback and no Done.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - InstrReady=1.
  - Accept on an edge with InstrValid=1; latch op/rd/ra/rb.
  - Legal op -> ISSUE. Illegal op -> DONE with Error=1; no ALU issue, no write.
- ISSUE (1 cycle): AluOp=op, AluA=regfile[ra], AluB=regfile[rb]. The ALU samples these at the closing edge. -> WAIT.
- WAIT (1 cycle):
  - AluOp=0, so the ALU holds its result.
  - AluResult is valid. At the closing edge, regfile[rd]<=AluResult.
  - If op=ADD: Flags[3]<=AluStatus[3], Flags[2]<=AluStatus[2], Flags[0]<=AluStatus[0], Flags[1]<=(AluResult==0).
  - Non-ADD ops leave Flags unchanged.
  - -> DONE.
- DONE (1 cycle): Done=1, Error as latched. -> IDLE.
- Latency:
  - Legal instruction accepted at edge N: ALU samples at N+1, writeback at N+2, Done high during cycle N+2..N+3.
  - Throughput is one instruction per 4 cycles.
  - Illegal instruction: Done during cycle N..N+1.
- Legal opcodes:
  - ADD 6'b010000, OR 6'b010001, NOR 6'b010010, XOR 6'b010011, RLS 6'b001100, LLS 6'b001101.
  - AND is not issued: its code aliases ADD at the ALU.
  - All other codes are illegal.
- AluOp is 6'b000000 outside ISSUE. The ALU ignores it, so ResultC holds.
- rd may equal ra or rb; operands are read in ISSUE, before writeback.
- Host preload:
  - Honoured only in IDLE; ignored in other states.
  - If a preload and an instruction accept occur on the same IDLE edge, the write lands first, and ISSUE reads the new value.
- All outputs except DbgData and InstrReady are registered.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams (OP_ADD, OP_OR, OP_NOR, OP_XOR, OP_RLS, OP_LLS).
  - Instruction field bit positions.
  - Flag bit indices (FLG_OVER=3, FLG_CARRY=2, FLG_ZERO=1, FLG_NEG=0).
  - State encoding.
- One sub-module: issue_regfile. It has 16x32 registers, two read ports (ra, rb), one debug read port, and one write port. The write port is muxed between the host preload and the writeback.

Test Plan:
- Preload R1=5, R2=3; ADD rd=3 ra=1 rb=2 -> AluOp=010000 in ISSUE; R3=8; Flags=4'b0000; Done 3 cycles after accept.
- R1=0x7FFFFFFF, R2=1; ADD rd=4 -> R4=0x80000000; Flags=4'b1001 (Over, Neg).
- R1=0xFFFFFFFF, R2=1; ADD rd=5 -> R5=0; Flags=4'b0110 (Carry, Zero).
- After test 3, XOR rd=6 with R1=0xF0F0F0F0, R2=0xFF00FF00 -> R6=0x0FF00FF0; Flags stay 4'b0110.
- Instr op=6'b111111 -> no AluOp activity; Done=1 and Error=1 the cycle after accept; all registers unchanged.
- Assert Reset during WAIT of ADD rd=7 -> R7=0, Flags=0, no Done; InstrReady=1 the cycle after Reset deasserts. Also check: HostWrEn during ISSUE is ignored.
